// File: rtl/axi_nport_arbiter.sv
// rtl/axi_nport_arbiter.sv - N-port burst client arbiter onto a single-outstanding AXI3 master
// Define ARB_ROUND_ROBIN_EN for round-robin grant; otherwise the lowest-index requester wins.
module axi_nport_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [NUM_PORTS-1:0]            req_valid,
    input  logic [NUM_PORTS-1:0]            req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]     req_addr,
    input  logic [NUM_PORTS*4-1:0]          req_len,
    input  logic [NUM_PORTS*3-1:0]          req_size,
    input  logic [NUM_PORTS*DATA_W-1:0]     req_wdata,
    input  logic [NUM_PORTS*(DATA_W/8)-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]            req_ready,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic [NUM_PORTS-1:0]            rsp_rvalid,
    output logic                            rsp_rlast,
    output logic [NUM_PORTS-1:0]            rsp_wnext,
    output logic [NUM_PORTS-1:0]            rsp_done,
    output logic                            rsp_err,
    output logic [3:0]                      arid,
    output logic [ADDR_W-1:0]               araddr,
    output logic [3:0]                      arlen,
    output logic [2:0]                      arsize,
    output logic [1:0]                      arburst,
    output logic                            arvalid,
    input  logic                            arready,
    input  logic [3:0]                      rid,
    input  logic [DATA_W-1:0]               rdata,
    input  logic [1:0]                      rresp,
    input  logic                            rlast,
    input  logic                            rvalid,
    output logic                            rready,
    output logic [3:0]                      awid,
    output logic [ADDR_W-1:0]               awaddr,
    output logic [3:0]                      awlen,
    output logic [2:0]                      awsize,
    output logic [1:0]                      awburst,
    output logic                            awvalid,
    input  logic                            awready,
    output logic [3:0]                      wid,
    output logic [DATA_W-1:0]               wdata,
    output logic [DATA_W/8-1:0]             wstrb,
    output logic                            wlast,
    output logic                            wvalid,
    input  logic                            wready,
    input  logic [3:0]                      bid,
    input  logic [1:0]                      bresp,
    input  logic                            bvalid,
    output logic                            bready
);

    localparam int SW = DATA_W / 8;

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

    state_t                state_q, state_d;
    logic [2:0]            g_q, g_d;
    logic [3:0]            len_q, len_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic [NUM_PORTS-1:0]  req_ready_q, req_ready_d;
    logic [NUM_PORTS-1:0]  rsp_done_q, rsp_done_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [3:0]            arid_q, arid_d;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic [3:0]            arlen_q, arlen_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [3:0]            awid_q, awid_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [3:0]            awlen_q, awlen_d;
    logic [2:0]            awsize_q, awsize_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [2:0]            ptr_q, ptr_d;
`endif

    logic                  any_req;
    logic [2:0]            win;
    logic [NUM_PORTS-1:0]  g_onehot;
    logic [DATA_W-1:0]     wdata_mux;
    logic [SW-1:0]         wstrb_mux;

    // Channel IDs, rresp[0] and bresp[0] carry nothing for a single-outstanding master.
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, rresp[0], bresp[0]};

    // Winner search: iterate offsets high to low so the smallest offset from the start point wins.
    always_comb begin
        any_req = |req_valid;
        win     = '0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            logic [3:0] sum;
            sum = {1'b0, ptr_q} + 4'(k);
            if (sum >= 4'(NUM_PORTS)) sum = sum - 4'(NUM_PORTS);
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (sum[2:0] == 3'(p) && req_valid[p]) win = 3'(p);
            end
        end
`else
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (req_valid[k]) win = 3'(k);
        end
`endif
    end

    always_comb begin
        g_onehot  = '0;
        wdata_mux = '0;
        wstrb_mux = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (g_q == 3'(k)) begin
                g_onehot[k] = 1'b1;
                wdata_mux   = req_wdata[k*DATA_W +: DATA_W];
                wstrb_mux   = req_wstrb[k*SW +: SW];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        g_d         = g_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        req_ready_d = '0;
        rsp_done_d  = '0;
        rsp_err_d   = 1'b0;
        arid_d      = arid_q;
        araddr_d    = araddr_q;
        arlen_d     = arlen_q;
        arsize_d    = arsize_q;
        awid_d      = awid_q;
        awaddr_d    = awaddr_q;
        awlen_d     = awlen_q;
        awsize_d    = awsize_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    g_d   = win;
                    cnt_d = '0;
                    err_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                    if (win == 3'(NUM_PORTS - 1)) ptr_d = '0;
                    else                          ptr_d = win + 3'd1;
`endif
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (win == 3'(k)) begin
                            req_ready_d[k] = 1'b1;
                            len_d          = req_len[k*4 +: 4];
                            if (req_write[k]) begin
                                awid_d   = {1'b0, win};
                                awaddr_d = req_addr[k*ADDR_W +: ADDR_W];
                                awlen_d  = req_len[k*4 +: 4];
                                awsize_d = req_size[k*3 +: 3];
                                state_d  = S_AW;
                            end else begin
                                arid_d   = {1'b0, win};
                                araddr_d = req_addr[k*ADDR_W +: ADDR_W];
                                arlen_d  = req_len[k*4 +: 4];
                                arsize_d = req_size[k*3 +: 3];
                                state_d  = S_AR;
                            end
                        end
                    end
                end
            end
            S_AR: if (arready) state_d = S_R;
            S_R: begin
                if (rvalid) begin
                    err_d = err_q | rresp[1];
                    if (rlast) begin
                        rsp_done_d = g_onehot;
                        rsp_err_d  = err_q | rresp[1];
                        state_d    = S_IDLE;
                    end
                end
            end
            S_AW: if (awready) state_d = S_W;
            S_W: begin
                if (wready) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == len_q) state_d = S_B;
                end
            end
            S_B: begin
                if (bvalid) begin
                    err_d      = bresp[1];
                    rsp_done_d = g_onehot;
                    rsp_err_d  = bresp[1];
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            g_q         <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            req_ready_q <= '0;
            rsp_done_q  <= '0;
            rsp_err_q   <= 1'b0;
            arid_q      <= '0;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            awid_q      <= '0;
            awaddr_q    <= '0;
            awlen_q     <= '0;
            awsize_q    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            g_q         <= g_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            req_ready_q <= req_ready_d;
            rsp_done_q  <= rsp_done_d;
            rsp_err_q   <= rsp_err_d;
            arid_q      <= arid_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            awid_q      <= awid_d;
            awaddr_q    <= awaddr_d;
            awlen_q     <= awlen_d;
            awsize_q    <= awsize_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    // Valids decode straight from the state register so reset clears them asynchronously.
    assign arvalid    = (state_q == S_AR);
    assign rready     = (state_q == S_R);
    assign awvalid    = (state_q == S_AW);
    assign wvalid     = (state_q == S_W);
    assign bready     = (state_q == S_B);
    assign wlast      = (state_q == S_W) && (cnt_q == len_q);
    assign wdata      = (state_q == S_W) ? wdata_mux : '0;
    assign wstrb      = (state_q == S_W) ? wstrb_mux : '0;
    assign wid        = awid_q;
    assign arid       = arid_q;
    assign araddr     = araddr_q;
    assign arlen      = arlen_q;
    assign arsize     = arsize_q;
    assign arburst    = 2'b01;
    assign awid       = awid_q;
    assign awaddr     = awaddr_q;
    assign awlen      = awlen_q;
    assign awsize     = awsize_q;
    assign awburst    = 2'b01;
    assign req_ready  = req_ready_q;
    assign rsp_done   = rsp_done_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = (state_q == S_R) ? rdata : '0;
    assign rsp_rvalid = (state_q == S_R && rvalid) ? g_onehot : '0;
    assign rsp_rlast  = (state_q == S_R) && rvalid && rlast;
    assign rsp_wnext  = (state_q == S_W && wready) ? g_onehot : '0;

endmodule

// File: tb/tb_axi_nport_arbiter.sv
// tb/tb_axi_nport_arbiter.sv - directed self-checking bench for axi_nport_arbiter
module tb_axi_nport_arbiter;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [NP-1:0]     req_valid, req_write;
    logic [NP*AW-1:0]  req_addr;
    logic [NP*4-1:0]   req_len;
    logic [NP*3-1:0]   req_size;
    logic [NP*DW-1:0]  req_wdata;
    logic [NP*4-1:0]   req_wstrb;
    logic [NP-1:0]     req_ready, rsp_rvalid, rsp_wnext, rsp_done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_rlast, rsp_err;
    logic [3:0]        arid, arlen, awid, awlen, wid, rid, bid;
    logic [AW-1:0]     araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic [1:0]        arburst, awburst, rresp, bresp;
    logic              arvalid, arready, rlast, rvalid, rready;
    logic              awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [DW-1:0]     rdata, wdata;
    logic [3:0]        wstrb;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axi_nport_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_rdata(rsp_rdata), .rsp_rvalid(rsp_rvalid), .rsp_rlast(rsp_rlast), .rsp_wnext(rsp_wnext),
        .rsp_done(rsp_done), .rsp_err(rsp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_grant(output int lat, output logic [NP-1:0] who);
        lat = 0;
        who = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge aclk);
            if (req_ready != '0) begin
                who = req_ready;
                lat = n;
                break;
            end
        end
        if (who == '0) chk("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_read(input int port, input logic [31:0] addr, input logic [3:0] len,
                           input int stall, input int errbeat, input logic exp_err);
        int            lat;
        logic [NP-1:0] who, oh;
        logic          ok;
        logic [31:0]   ed;
        oh = NP'(1) << port;
        req_addr[port*AW +: AW] = addr;
        req_len[port*4 +: 4]    = len;
        req_write[port]         = 1'b0;
        req_valid[port]         = 1'b1;
        wait_grant(lat, who);
        chk("rd_grant", {who, 4'(lat)}, {oh, 4'd1});
        chk("rd_ar", {arvalid, awvalid, arid, arlen, arburst, araddr},
                     {1'b1, 1'b0, 4'(port), len, 2'b01, addr});
        @(posedge aclk); #1 req_valid[port] = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            if (arvalid !== 1'b1 || araddr !== addr || arlen !== len || arid !== 4'(port)) ok = 1'b0;
            @(posedge aclk); #1;
        end
        if (stall > 0) chk("ar_stall_stable", {63'd0, ok}, 64'd1);
        arready = 1'b1;
        @(posedge aclk); #1 arready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            ed     = 32'hA0 + 32'(b);
            rvalid = 1'b1;
            rdata  = ed;
            rresp  = (b == errbeat) ? 2'b10 : 2'b00;
            rlast  = (b == int'(len));
            @(negedge aclk);
            chk("rd_beat", {rready, rsp_rvalid, rsp_rlast, rsp_done, rsp_rdata},
                           {1'b1, oh, (b == int'(len)), {NP{1'b0}}, ed});
            @(posedge aclk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        @(negedge aclk);
        chk("rd_done", {rsp_done, rsp_err, rready, rsp_rvalid}, {oh, exp_err, 1'b0, {NP{1'b0}}});
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("rd_done_pulse", {rsp_done, rsp_err}, '0);
        @(posedge aclk); #1;
    endtask

    task automatic do_write(input int port, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] d [4], input int stall);
        int            lat;
        logic [NP-1:0] who, oh;
        oh = NP'(1) << port;
        req_addr[port*AW +: AW]  = addr;
        req_len[port*4 +: 4]     = len;
        req_write[port]          = 1'b1;
        req_wdata[port*DW +: DW] = d[0];
        req_wstrb[port*4 +: 4]   = 4'hF;
        req_valid[port]          = 1'b1;
        wait_grant(lat, who);
        chk("wr_grant", {who, 4'(lat)}, {oh, 4'd1});
        chk("wr_aw", {awvalid, arvalid, awid, awlen, awaddr}, {1'b1, 1'b0, 4'(port), len, addr});
        @(posedge aclk); #1 req_valid[port] = 1'b0; awready = 1'b1;
        @(posedge aclk); #1 awready = 1'b0;
        for (int b = 0; b <= int'(len); b++) begin
            for (int s = 0; s < ((b == 0) ? stall : 0); s++) begin
                @(negedge aclk);
                chk("wr_wait", {wvalid, rsp_wnext, wlast}, {1'b1, {NP{1'b0}}, 1'b0});
                @(posedge aclk); #1;
            end
            wready = 1'b1;
            @(negedge aclk);
            chk("wr_beat", {wvalid, wid, rsp_wnext, wlast, wstrb, wdata},
                           {1'b1, 4'(port), oh, (b == int'(len)), 4'hF, d[b]});
            @(posedge aclk); #1 wready = 1'b0;
            if (b < 3) req_wdata[port*DW +: DW] = d[b+1];
        end
        bvalid = 1'b1;
        bresp  = 2'b00;
        @(negedge aclk);
        chk("wr_b", {bready, wvalid, rsp_done}, {1'b1, 1'b0, {NP{1'b0}}});
        @(posedge aclk); #1 bvalid = 1'b0;
        @(negedge aclk);
        chk("wr_done", {rsp_done, rsp_err}, {oh, 1'b0});
        @(posedge aclk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        int            lat;
        logic [NP-1:0] who;
        logic [NP-1:0] order [4];
        logic [NP-1:0] exp_order [4];
        logic [31:0]   wd [4];

        aresetn   = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0; req_len = '0;
        req_size  = {NP{3'd2}}; req_wdata = '0; req_wstrb = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
        rvalid = 1'b0; rlast = 1'b0; rresp = '0; rdata = 32'hDEAD_BEEF; rid = '0;

        repeat (3) @(negedge aclk);
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready, wlast}, '0);
        chk("rst_pulses", {req_ready, rsp_done, rsp_rvalid, rsp_wnext, rsp_err}, '0);
        chk("rst_addr", {araddr, awaddr}, '0);
        chk("rst_data", {arid, awid, wdata, rsp_rdata}, '0);
        @(posedge aclk); #1 aresetn = 1'b1;
        @(posedge aclk); #1;

        do_read(1, 32'h1fc0_0000, 4'd3, 0, -1, 1'b0);

        wd = '{32'h11, 32'h22, 32'h0, 32'h0};
        do_write(0, 32'h0000_4000, 4'd1, wd, 2);

        do_read(2, 32'h0000_1000, 4'd3, 5, 1, 1'b1);
        do_read(0, 32'h0000_2000, 4'd0, 0, -1, 1'b0);

        // Abandon a write burst with reset while beat 2 is pending.
        req_addr[0 +: AW] = 32'h0000_3000; req_len[0 +: 4] = 4'd3; req_write[0] = 1'b1;
        req_wdata[0 +: DW] = 32'h55; req_wstrb[0 +: 4] = 4'hF; req_valid[0] = 1'b1;
        wait_grant(lat, who);
        @(posedge aclk); #1 req_valid[0] = 1'b0; awready = 1'b1;
        @(posedge aclk); #1 awready = 1'b0; wready = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1 wready = 1'b0;
        @(negedge aclk);
        chk("mid_w_pending", {wvalid, wlast}, {1'b1, 1'b0});
        #1 aresetn = 1'b0;
        #1;
        chk("mid_rst_async", {arvalid, awvalid, wvalid, rready, bready, wlast}, '0);
        chk("mid_rst_pulses", {req_ready, rsp_done, rsp_wnext}, '0);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("mid_no_done", {rsp_done, wvalid}, '0);
        #1 aresetn = 1'b1;
        @(posedge aclk); #1;
        @(negedge aclk);
        chk("post_rst_idle", {rsp_done, wvalid, awvalid, arvalid}, '0);
        @(posedge aclk); #1;
        do_read(2, 32'h0000_5000, 4'd1, 0, -1, 1'b0);

        // Every port requests continuously; record the first four grants.
        req_write = '0;
        req_len   = '0;
        req_valid = '1;
        for (int t = 0; t < 4; t++) begin
            wait_grant(lat, who);
            order[t] = who;
            @(posedge aclk); #1 arready = 1'b1;
            @(posedge aclk); #1 arready = 1'b0; rvalid = 1'b1; rlast = 1'b1; rdata = 32'(t);
            @(posedge aclk); #1 rvalid = 1'b0; rlast = 1'b0;
        end
        req_valid = '0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{3'b001, 3'b010, 3'b100, 3'b001};
`else
        exp_order = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif
        for (int t = 0; t < 4; t++) chk("arb_order", {61'd0, order[t]}, {61'd0, exp_order[t]});
        @(negedge aclk);
        chk("arb_done_last", rsp_done, 3'b001);
        repeat (2) @(negedge aclk);
        chk("arb_quiet", {req_ready, arvalid, awvalid}, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
